// File: rtl/arb_fsm_param.sv
// N-requester grant FSM: fixed-priority or round-robin, registered one-hot grant.
// Define ARB_HOLD_TIMEOUT_EN to preempt an owner after MAX_HOLD consecutive grant cycles.
module arb_fsm_param #(
  parameter int N        = 3,
  parameter int MAX_HOLD = 8,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   r,
  input  logic           rr_mode,
  output logic [N-1:0]   g,
  output logic           gnt_valid,
  output logic [IDW-1:0] gnt_id,
  output logic           preempt
);

  if (N < 2 || N > 32 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : gParamCheck
    $error("arb_fsm_param: N must be 2..32 and MAX_HOLD 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           newGrant;
  logic [N-1:0]   candidates;
  logic [IDW-1:0] winner;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);
  localparam logic [7:0] HOLD_SAT   = 8'(MAX_HOLD);

  logic [7:0] holdCnt_q, holdCnt_d;
  logic       preempt_q, preempt_d;
`endif

  function automatic logic [IDW-1:0] lowestSet(input logic [N-1:0] v);
    lowestSet = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) lowestSet = IDW'(i);
    end
  endfunction

  // Round-robin prefers requests at or above the pointer and wraps to the lowest one otherwise.
  function automatic logic [IDW-1:0] pickWinner(input logic [N-1:0] req,
                                                input logic [IDW-1:0] ptr,
                                                input logic rr);
    logic [N-1:0] upper;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
    if (rr && (upper != '0)) pickWinner = lowestSet(upper);
    else                     pickWinner = lowestSet(req);
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    newGrant   = 1'b0;
    candidates = r;
    winner     = '0;
`ifdef ARB_HOLD_TIMEOUT_EN
    holdCnt_d  = holdCnt_q;
    preempt_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (r != '0) newGrant = 1'b1;
      end
      GRANT: begin
        if (!r[owner_q]) begin
          if (r != '0) begin
            newGrant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            owner_d = '0;
          end
        end
`ifdef ARB_HOLD_TIMEOUT_EN
        // grant_q is the owner's one-hot, so masking with it drops the owner from the contest.
        else if (holdCnt_q >= HOLD_LIMIT && (r & ~grant_q) != '0) begin
          newGrant   = 1'b1;
          candidates = r & ~grant_q;
          preempt_d  = 1'b1;
        end else if (holdCnt_q != HOLD_SAT) begin
          holdCnt_d = holdCnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        owner_d = '0;
      end
    endcase

    if (newGrant) begin
      winner          = pickWinner(candidates, ptr_q, rr_mode);
      state_d         = GRANT;
      grant_d         = '0;
      grant_d[winner] = 1'b1;
      owner_d         = winner;
      ptr_d           = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;
    end

`ifdef ARB_HOLD_TIMEOUT_EN
    if (newGrant || state_d == IDLE) holdCnt_d = '0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_HOLD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdCnt_q <= '0;
      preempt_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  assign g         = grant_q;
  assign gnt_valid = (state_q == GRANT);
  assign gnt_id    = owner_q;

endmodule

// File: tb/tb_arb_fsm_param.sv
// Bench for arb_fsm_param: N=3 (MAX_HOLD=4) and N=8 instances against a behavioural model.
// Timeout expectations follow ARB_HOLD_TIMEOUT_EN when it is defined for the build.
module tb_arb_fsm_param;

  localparam int MH3 = 4;
  localparam int MH8 = 8;

  typedef struct packed {
    int owner;
    int ptr;
    int served;
    bit pre;
  } mdl_t;

  localparam mdl_t IDLE_M = '{owner: -1, ptr: 0, served: 0, pre: 1'b0};

  logic       clk    = 1'b0;
  logic       reset  = 1'b1;
  logic       rrMode = 1'b0;
  logic [2:0] r3     = '0;
  logic [7:0] r8     = '0;
  logic [2:0] g3;
  logic [1:0] id3;
  logic       valid3, pre3;
  logic [7:0] g8;
  logic [2:0] id8;
  logic       valid8, pre8;

  int   assertCount = 0;
  int   failCount   = 0;
  bit   checkEn     = 1'b0;
  mdl_t m3          = IDLE_M;
  mdl_t m8          = IDLE_M;

  logic [2:0] rrReq [6] = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b011};
  logic [2:0] rrExp [6] = '{3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
  logic [2:0] fxReq [6] = '{3'b111, 3'b110, 3'b111, 3'b101, 3'b111, 3'b110};
  logic [2:0] fxExp [6] = '{3'b001, 3'b010, 3'b010, 3'b001, 3'b001, 3'b010};
`ifdef ARB_HOLD_TIMEOUT_EN
  logic [2:0] toExp [12] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b010,
                             3'b010, 3'b010, 3'b001, 3'b001, 3'b001, 3'b001};
  logic [11:0] toPre = 12'b0001_0001_0000;
`else
  logic [2:0] toExp [12] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
                             3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
  logic [11:0] toPre = 12'b0;
`endif

  arb_fsm_param #(.N(3), .MAX_HOLD(MH3)) u3 (
    .clk(clk), .reset(reset), .r(r3), .rr_mode(rrMode),
    .g(g3), .gnt_valid(valid3), .gnt_id(id3), .preempt(pre3)
  );

  arb_fsm_param #(.N(8), .MAX_HOLD(MH8)) u8 (
    .clk(clk), .reset(reset), .r(r8), .rr_mode(rrMode),
    .g(g8), .gnt_valid(valid8), .gnt_id(id8), .preempt(pre8)
  );

  always #5 clk = ~clk;

  function automatic int pickWinner(logic [31:0] req, int n, int ptr, bit rr);
    int idx;
    for (int i = 0; i < n; i++) begin
      idx = rr ? (ptr + i) % n : i;
      if (req[idx]) return idx;
    end
    return -1;
  endfunction

  // Owner keeps the grant while its request is live; otherwise the live requests re-arbitrate.
  function automatic mdl_t stepModel(mdl_t m, logic [31:0] req, int n, bit rr, int maxHold);
    mdl_t nx;
    int   w;
`ifdef ARB_HOLD_TIMEOUT_EN
    logic [31:0] others;
`endif
    nx     = m;
    nx.pre = 1'b0;
    if (m.owner >= 0 && req[m.owner]) begin
`ifdef ARB_HOLD_TIMEOUT_EN
      others = req & ~(32'd1 << m.owner);
      if (m.served >= maxHold && others != 0) begin
        w         = pickWinner(others, n, m.ptr, rr);
        nx.owner  = w;
        nx.ptr    = (w + 1) % n;
        nx.served = 1;
        nx.pre    = 1'b1;
      end else
`endif
      if (m.served < maxHold) nx.served = m.served + 1;
    end else if (req == 0) begin
      nx.owner  = -1;
      nx.served = 0;
    end else begin
      w         = pickWinner(req, n, m.ptr, rr);
      nx.owner  = w;
      nx.ptr    = (w + 1) % n;
      nx.served = 1;
    end
    return nx;
  endfunction

  function automatic logic [31:0] modelGrant(mdl_t m);
    return (m.owner < 0) ? 32'd0 : (32'd1 << m.owner);
  endfunction

  function automatic logic [31:0] modelPreempt(mdl_t m);
`ifdef ARB_HOLD_TIMEOUT_EN
    return 32'(m.pre);
`else
    return (m.owner < -1) ? 32'd1 : 32'd0;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m3 <= IDLE_M;
      m8 <= IDLE_M;
    end else begin
      m3 <= stepModel(m3, 32'(r3), 3, rrMode, MH3);
      m8 <= stepModel(m8, 32'(r8), 8, rrMode, MH8);
    end
  end

  task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic compareModel(string tag, mdl_t m, logic [31:0] gAct, logic [31:0] idAct,
                              logic vAct, logic pAct);
    check({tag, " g"}, gAct, modelGrant(m));
    check({tag, " gnt_id"}, idAct, (m.owner < 0) ? 32'd0 : 32'(m.owner));
    check({tag, " gnt_valid"}, 32'(vAct), (m.owner >= 0) ? 32'd1 : 32'd0);
    check({tag, " preempt"}, 32'(pAct), modelPreempt(m));
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      compareModel("cyc3", m3, 32'(g3), 32'(id3), valid3, pre3);
      compareModel("cyc8", m8, 32'(g8), 32'(id8), valid8, pre8);
    end
  end

  task automatic applyStimulus(logic [2:0] v3, logic [7:0] v8, logic rr);
    r3     = v3;
    r8     = v8;
    rrMode = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(string name, logic [2:0] expG, logic expPre);
    int expId = 0;
    for (int i = 0; i < 3; i++) if (expG[i]) expId = i;
    check({name, " g"}, 32'(g3), 32'(expG));
    check({name, " gnt_id"}, 32'(id3), 32'(expId));
    check({name, " gnt_valid"}, 32'(valid3), 32'(expG != 3'b000));
    check({name, " preempt"}, 32'(pre3), 32'(expPre));
    check({name, " model"}, modelGrant(m3), 32'(expG));
  endtask

  task automatic checkOutput8(string name, logic [7:0] expG);
    int expId = 0;
    for (int i = 0; i < 8; i++) if (expG[i]) expId = i;
    check({name, " g8"}, 32'(g8), 32'(expG));
    check({name, " gnt_id8"}, 32'(id8), 32'(expId));
    check({name, " gnt_valid8"}, 32'(valid8), 32'(expG != 8'h00));
    check({name, " model8"}, modelGrant(m8), 32'(expG));
  endtask

  initial begin
    logic [2:0] nr3;
    logic [7:0] nr8;
    logic       nrr;

    repeat (2) @(posedge clk);
    #1;
    checkEn = 1'b1;
    checkOutput("reset", 3'b000, 1'b0);
    checkOutput8("reset", 8'h00);
    reset = 1'b0;

    applyStimulus(3'b110, 8'h00, 1'b0);
    checkOutput("fixed pick", 3'b010, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(3'b010, 8'h00, 1'b0);
      checkOutput("hold", 3'b010, 1'b0);
    end
    applyStimulus(3'b100, 8'h00, 1'b0);
    checkOutput("handoff", 3'b100, 1'b0);
    applyStimulus(3'b000, 8'h00, 1'b0);
    checkOutput("idle", 3'b000, 1'b0);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(rrReq[i], 8'h00, 1'b1);
      checkOutput("rr seq", rrExp[i], 1'b0);
    end

    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b000, 8'h00, 1'b1);
      checkOutput("drop to idle", 3'b000, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      applyStimulus(fxReq[i], 8'h00, 1'b0);
      checkOutput("fixed seq", fxExp[i], 1'b0);
    end

    applyStimulus(3'b100, 8'h00, 1'b0);
    checkOutput("pre reset", 3'b100, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("async reset", 3'b000, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    applyStimulus(3'b111, 8'h00, 1'b1);
    checkOutput("ptr after reset", 3'b001, 1'b0);

    applyStimulus(3'b000, 8'h80, 1'b0);
    checkOutput8("n8 top", 8'h80);
    applyStimulus(3'b000, 8'h81, 1'b0);
    checkOutput8("n8 hold", 8'h80);
    applyStimulus(3'b000, 8'h01, 1'b0);
    checkOutput8("n8 low", 8'h01);

    applyStimulus(3'b000, 8'h00, 1'b0);
    checkOutput("timeout idle", 3'b000, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(3'b011, 8'h00, 1'b0);
      checkOutput("timeout seq", toExp[i], toPre[i]);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(3'b001, 8'h00, 1'b0);
      checkOutput("sole owner", 3'b001, 1'b0);
    end

    // Sticky random requests so owners hold long enough to hit timeouts and hand-offs.
    nr3 = 3'b000;
    nr8 = 8'h00;
    nrr = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) nr3 = 3'($urandom);
      if ($urandom_range(0, 3) == 0) nr8 = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0) nrr = ~nrr;
      r3     = nr3;
      r8     = nr8;
      rrMode = nrr;
      if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
        #1 reset = 1'b0;
      end
      @(posedge clk);
      #1;
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
